fpu_cvt_to_float_pipe: RTL and testbench

- Pipelined integer-to-single-precision converter for the FPU arithmetic unit, implementing FCVT.S.W/WU and FCVT.S.L/LU.
- Generalises the combinational converter to a parametrised integer width with a 3-stage elastic valid/ready pipeline.
- Adds all five RISC-V rounding modes, an inexact (NX) flag, a pass-through tag and a pipeline flush.
- Sits between the FPU issue logic and the FP writeback arbiter.

---
 rtl/fpu_cvt_to_float_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_fpu_cvt_to_float_pipe.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cvt_to_float_pipe.sv
// Pipelined integer to IEEE-754 binary32 converter (FCVT.S.W/WU/L/LU).
// Three elastic stages: accept (sign/magnitude), normalise (leading-zero
// shift, guard/round/sticky extraction), round/pack (output registers).
// Handshake is valid/ready on both sides; flush kills everything in flight.
module fpu_cvt_to_float_pipe #(
  parameter int INT_WIDTH = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 is_unsigned_i,
  input  logic [2:0]           rounding_mode_i,
  input  logic [INT_WIDTH-1:0] operand_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          result_o,
  output logic                 nx_o,
  output logic [TAG_WIDTH-1:0] tag_o
);

  // Leading-zero count must be able to represent INT_WIDTH itself (zero input).
  localparam int LZC_W = $clog2(INT_WIDTH) + 1;

  // Biased exponent of a value whose top set bit is the operand MSB.
  localparam logic [7:0] EXP_TOP = 8'(127 + INT_WIDTH - 1);

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Priority scan from the MSB; stops counting at the first set bit.
  function automatic logic [LZC_W-1:0] lead_zeros(input logic [INT_WIDTH-1:0] v);
    logic found;
    lead_zeros = '0;
    found      = 1'b0;
    for (int i = INT_WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      lead_zeros = lead_zeros + LZC_W'(1);
      end
    end
  endfunction

  // ---------------------------------------------------------------------
  // Stage occupancy and handshake
  // ---------------------------------------------------------------------
  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic s1_take, s2_take, s3_take;   // stage may load a new entry this cycle
  logic in_fire, s1_fire, s2_fire;   // entry moves into S1 / S2 / S3

  // A stage can load when it is empty or its current entry leaves this cycle.
  // Only downstream ready and the valid bits feed this chain, so in_ready_o
  // never depends on in_valid_i or flush_i.
  assign s3_take    = ~s3_valid_q | out_ready_i;
  assign s2_take    = ~s2_valid_q | s3_take;
  assign s1_take    = ~s1_valid_q | s2_take;
  assign in_ready_o = s1_take;

  assign in_fire = in_valid_i & s1_take;
  assign s1_fire = s1_valid_q & s2_take;
  assign s2_fire = s2_valid_q & s3_take;

  assign out_valid_o = s3_valid_q;

  // Valid bits: reset and flush empty the pipe, otherwise each loading stage
  // inherits its predecessor's valid.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every stage
    // samples its predecessor's pre-edge value, not a freshly updated one.
    if (reset_i || flush_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
    end else begin
      if (s1_take) s1_valid_q <= in_valid_i;
      if (s2_take) s2_valid_q <= s1_valid_q;
      if (s3_take) s3_valid_q <= s2_valid_q;
    end
  end

  // ---------------------------------------------------------------------
  // S1: accept -- sign and magnitude
  // ---------------------------------------------------------------------
  logic                 s1_sign_d, s1_sign_q;
  logic [INT_WIDTH-1:0] s1_mag_d, s1_mag_q;
  logic                 s1_zero_d, s1_zero_q;
  logic [2:0]           s1_rm_q;
  logic [TAG_WIDTH-1:0] s1_tag_q;

  // Two's-complement negate for negative signed operands; the most negative
  // value maps to 2^(INT_WIDTH-1), which still fits as an unsigned magnitude.
  always_comb begin
    s1_sign_d = ~is_unsigned_i & operand_i[INT_WIDTH-1];
    s1_mag_d  = s1_sign_d ? (~operand_i + INT_WIDTH'(1)) : operand_i;
    s1_zero_d = (operand_i == '0);
  end

  // S1 payload capture on an accepted operand.
  always_ff @(posedge clk_i) begin
    // NOTE: payload registers carry no reset; the valid bits alone decide
    // whether their contents mean anything.
    if (in_fire) begin
      s1_sign_q <= s1_sign_d;
      s1_mag_q  <= s1_mag_d;
      s1_zero_q <= s1_zero_d;
      s1_rm_q   <= rounding_mode_i;
      s1_tag_q  <= tag_i;
    end
  end

  // ---------------------------------------------------------------------
  // S2: normalise -- leading-zero shift, exponent, G/R/S
  // ---------------------------------------------------------------------
  logic [LZC_W-1:0]     s2_lzc;
  logic [INT_WIDTH-1:0] s2_norm;
  logic [7:0]           s2_exp_d, s2_exp_q;
  logic [22:0]          s2_frac_d, s2_frac_q;
  logic                 s2_guard_d, s2_guard_q;
  logic                 s2_round_d, s2_round_q;
  logic                 s2_sticky_d, s2_sticky_q;
  logic                 s2_sign_q, s2_zero_q;
  logic [2:0]           s2_rm_q;
  logic [TAG_WIDTH-1:0] s2_tag_q;

  // After the shift the hidden bit sits at the MSB; the 23 bits below it are
  // the fraction, then guard, round, and everything further down ORs into
  // sticky. A zero magnitude keeps a zero exponent field.
  always_comb begin
    s2_lzc      = lead_zeros(s1_mag_q);
    s2_norm     = s1_mag_q << s2_lzc;
    s2_exp_d    = s2_norm[INT_WIDTH-1] ? (EXP_TOP - 8'(s2_lzc)) : 8'd0;
    s2_frac_d   = s2_norm[INT_WIDTH-2 -: 23];
    s2_guard_d  = s2_norm[INT_WIDTH-25];
    s2_round_d  = s2_norm[INT_WIDTH-26];
    s2_sticky_d = |s2_norm[INT_WIDTH-27:0];
  end

  // S2 payload capture when the S1 entry moves forward.
  always_ff @(posedge clk_i) begin
    if (s1_fire) begin
      s2_exp_q    <= s2_exp_d;
      s2_frac_q   <= s2_frac_d;
      s2_guard_q  <= s2_guard_d;
      s2_round_q  <= s2_round_d;
      s2_sticky_q <= s2_sticky_d;
      s2_sign_q   <= s1_sign_q;
      s2_zero_q   <= s1_zero_q;
      s2_rm_q     <= s1_rm_q;
      s2_tag_q    <= s1_tag_q;
    end
  end

  // ---------------------------------------------------------------------
  // S3: round and pack into the output registers
  // ---------------------------------------------------------------------
  logic        inexact;
  logic        round_up;
  logic [30:0] packed_rnd;
  logic [31:0] s3_result_d;
  logic        s3_nx_d;

  assign inexact = s2_guard_q | s2_round_q | s2_sticky_q;

  // Increment decision per rounding mode; unused encodings behave as RNE.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // round_up unassigned, which would otherwise infer a latch.
    round_up = 1'b0;
    case (s2_rm_q)
      RM_RTZ:  round_up = 1'b0;
      RM_RDN:  round_up = s2_sign_q & inexact;
      RM_RUP:  round_up = ~s2_sign_q & inexact;
      RM_RMM:  round_up = s2_guard_q;
      RM_RNE:  round_up = s2_guard_q & (s2_round_q | s2_sticky_q | s2_frac_q[0]);
      default: round_up = s2_guard_q & (s2_round_q | s2_sticky_q | s2_frac_q[0]);
    endcase
  end

  // Adding the increment to {exponent, fraction} lets a fraction carry-out
  // bump the exponent and leave a zero fraction in one adder. The largest
  // rounded magnitude is 2^64, so the exponent never reaches 255.
  always_comb begin
    packed_rnd  = {s2_exp_q, s2_frac_q} + 31'(round_up);
    s3_result_d = s2_zero_q ? 32'd0 : {s2_sign_q, packed_rnd};
    s3_nx_d     = ~s2_zero_q & inexact;
  end

  // Output registers: cleared by reset, loaded only when S3 takes an entry,
  // so they hold steady while the result is stalled.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      result_o <= 32'd0;
      nx_o     <= 1'b0;
      tag_o    <= '0;
    end else if (s2_fire) begin
      result_o <= s3_result_d;
      nx_o     <= s3_nx_d;
      tag_o    <= s2_tag_q;
    end
  end

endmodule

// File: tb/tb_fpu_cvt_to_float_pipe.sv
// Self-checking bench for fpu_cvt_to_float_pipe: directed vectors on a
// 32-bit and a 64-bit instance, backpressure, flush, mid-flight reset and a
// randomized elastic stream scored against a reference conversion model.
module tb_fpu_cvt_to_float_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 32-bit instance signals
  logic        flush32, in_valid32, uns32, out_ready32;
  logic        in_ready32, out_valid32, nx32;
  logic [2:0]  rm32;
  logic [31:0] op32, result32;
  logic [4:0]  tag32, tag_o32;

  // 64-bit instance signals
  logic        flush64, in_valid64, uns64, out_ready64;
  logic        in_ready64, out_valid64, nx64;
  logic [2:0]  rm64;
  logic [63:0] op64;
  logic [31:0] result64;
  logic [4:0]  tag64, tag_o64;

  fpu_cvt_to_float_pipe #(.INT_WIDTH(32), .TAG_WIDTH(5)) dut32 (
    .clk_i(clk), .reset_i(reset), .flush_i(flush32),
    .in_valid_i(in_valid32), .in_ready_o(in_ready32),
    .is_unsigned_i(uns32), .rounding_mode_i(rm32),
    .operand_i(op32), .tag_i(tag32),
    .out_valid_o(out_valid32), .out_ready_i(out_ready32),
    .result_o(result32), .nx_o(nx32), .tag_o(tag_o32)
  );

  fpu_cvt_to_float_pipe #(.INT_WIDTH(64), .TAG_WIDTH(5)) dut64 (
    .clk_i(clk), .reset_i(reset), .flush_i(flush64),
    .in_valid_i(in_valid64), .in_ready_o(in_ready64),
    .is_unsigned_i(uns64), .rounding_mode_i(rm64),
    .operand_i(op64), .tag_i(tag64),
    .out_valid_o(out_valid64), .out_ready_i(out_ready64),
    .result_o(result64), .nx_o(nx64), .tag_o(tag_o64)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", name, obs, exp);
    end
  endtask

  // Reference: exact integer -> binary32 via quotient/remainder arithmetic.
  // Returns {nx, result}.
  function automatic logic [32:0] ref_cvt(input logic [63:0] op, input int w,
                                          input logic uns, input logic [2:0] rm);
    logic [63:0] mask, v, m, q, rem, half;
    logic        sign, up, inexact;
    int          e, sh;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    v    = op & mask;
    sign = !uns && v[w-1];
    m    = sign ? ((~v + 64'd1) & mask) : v;
    if (m == 64'd0) return 33'd0;
    e = 0;
    for (int i = 0; i < 64; i++) if (m[i]) e = i;
    if (e <= 23) begin
      q    = m << (23 - e);
      rem  = 64'd0;
      half = 64'd1;
    end else begin
      sh   = e - 23;
      q    = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
    end
    inexact = (rem != 64'd0);
    case (rm)
      3'b001:  up = 1'b0;
      3'b010:  up = sign && inexact;
      3'b011:  up = !sign && inexact;
      3'b100:  up = (rem >= half);
      default: up = (rem > half) || ((rem == half) && q[0]);
    endcase
    q = q + {63'd0, up};
    if (q == 64'h100_0000) begin
      q = 64'h80_0000;
      e = e + 1;
    end
    return {inexact, sign, 8'(e + 127), q[22:0]};
  endfunction

  typedef struct packed {
    logic        uns;
    logic [2:0]  rm;
    logic [63:0] op;
    logic [4:0]  tag;
  } op_t;

  typedef struct packed {
    logic [31:0] res;
    logic        nx;
    logic [4:0]  tag;
  } exp_t;

  op_t  pend_q[$];
  exp_t exp_q[$];
  int   accepted  = 0;
  int   delivered = 0;
  bit   hold_v    = 1'b0;
  exp_t hold;
  logic last_in_ready, last_out_valid;
  logic [4:0] tag_ctr = 5'd0;

  function automatic exp_t expect32(input op_t o);
    logic [32:0] r;
    exp_t e;
    r     = ref_cvt(o.op, 32, o.uns, o.rm);
    e.res = r[31:0];
    e.nx  = r[32];
    e.tag = o.tag;
    return e;
  endfunction

  function automatic op_t rand_op(input logic [4:0] tag);
    op_t o;
    o.uns = 1'($urandom_range(0, 1));
    o.rm  = 3'($urandom_range(0, 7));
    o.tag = tag;
    case ($urandom_range(0, 5))
      0:       o.op = {$urandom, $urandom};
      1:       o.op = {$urandom, $urandom} >> $urandom_range(0, 63);
      2:       o.op = 64'd1 << $urandom_range(0, 63);
      3:       o.op = 64'hFFFF_FFFF_FFFF_FFFF >> $urandom_range(0, 63);
      4:       o.op = (64'hFF_FFFF + 64'($urandom_range(0, 4))) << $urandom_range(0, 8);
      default: o.op = 64'd0;
    endcase
    return o;
  endfunction

  // One clock of the 32-bit stream: drive the queue head (if wanted), then
  // score any output handshake and any held (stalled) output.
  task automatic cycle32(input bit want_v, input bit rdy, input bit fl);
    op_t  o;
    exp_t e;
    @(negedge clk);
    out_ready32 = rdy;
    flush32     = fl;
    o           = '0;
    if (want_v && pend_q.size() > 0) begin
      o          = pend_q[0];
      in_valid32 = 1'b1;
      uns32      = o.uns;
      rm32       = o.rm;
      op32       = o.op[31:0];
      tag32      = o.tag;
    end else begin
      in_valid32 = 1'b0;
    end
    #1;
    if (hold_v) begin
      check("stall_valid", out_valid32, 1);
      check("stall_result", result32, hold.res);
      check("stall_nx", nx32, hold.nx);
      check("stall_tag", tag_o32, hold.tag);
    end
    if (out_valid32 && rdy) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid32, 0);
      end else begin
        e = exp_q.pop_front();
        check("stream_result", result32, e.res);
        check("stream_nx", nx32, e.nx);
        check("stream_tag", tag_o32, e.tag);
        delivered++;
      end
    end
    if (in_valid32 && in_ready32) begin
      accepted++;
      if (!fl) exp_q.push_back(expect32(o));
      void'(pend_q.pop_front());
    end
    last_in_ready  = in_ready32;
    last_out_valid = out_valid32;
    hold_v         = out_valid32 && !rdy && !fl;
    hold.res       = result32;
    hold.nx        = nx32;
    hold.tag       = tag_o32;
  endtask

  // Isolated operation on the 32-bit instance with latency measurement.
  task automatic single32(input string name, input logic uns, input logic [2:0] rm,
                          input logic [31:0] op, input logic [4:0] tag,
                          input logic [31:0] exp_res, input logic exp_nx);
    int lat;
    bit got;
    @(negedge clk);
    flush32 = 1'b0; out_ready32 = 1'b1;
    in_valid32 = 1'b1; uns32 = uns; rm32 = rm; op32 = op; tag32 = tag;
    #1;
    check({name, "_accept"}, in_ready32, 1);
    lat = 0; got = 1'b0;
    for (int n = 1; n <= 8 && !got; n++) begin
      @(negedge clk);
      in_valid32 = 1'b0;
      #1;
      if (out_valid32) begin
        got = 1'b1;
        lat = n;
      end
    end
    check({name, "_latency"}, 64'(lat), 3);
    check({name, "_result"}, result32, exp_res);
    check({name, "_nx"}, nx32, exp_nx);
    check({name, "_tag"}, tag_o32, tag);
  endtask

  task automatic single64(input string name, input logic uns, input logic [2:0] rm,
                          input logic [63:0] op, input logic [4:0] tag,
                          input logic [31:0] exp_res, input logic exp_nx);
    int lat;
    bit got;
    @(negedge clk);
    flush64 = 1'b0; out_ready64 = 1'b1;
    in_valid64 = 1'b1; uns64 = uns; rm64 = rm; op64 = op; tag64 = tag;
    #1;
    check({name, "_accept"}, in_ready64, 1);
    lat = 0; got = 1'b0;
    for (int n = 1; n <= 8 && !got; n++) begin
      @(negedge clk);
      in_valid64 = 1'b0;
      #1;
      if (out_valid64) begin
        got = 1'b1;
        lat = n;
      end
    end
    check({name, "_latency"}, 64'(lat), 3);
    check({name, "_result"}, result64, exp_res);
    check({name, "_nx"}, nx64, exp_nx);
    check({name, "_tag"}, tag_o64, tag);
  endtask

  initial begin
    int a0, d0;
    logic [32:0] r;
    op_t o;

    // ---- reset ----
    reset = 1'b1;
    flush32 = 1'b0; in_valid32 = 1'b0; uns32 = 1'b0; rm32 = 3'd0;
    op32 = '0; tag32 = '0; out_ready32 = 1'b1;
    flush64 = 1'b0; in_valid64 = 1'b0; uns64 = 1'b0; rm64 = 3'd0;
    op64 = '0; tag64 = '0; out_ready64 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst32_out_valid", out_valid32, 0);
    check("rst32_result", result32, 0);
    check("rst32_nx", nx32, 0);
    check("rst32_tag", tag_o32, 0);
    check("rst32_in_ready", in_ready32, 1);
    check("rst64_out_valid", out_valid64, 0);
    check("rst64_in_ready", in_ready64, 1);
    reset = 1'b0;

    // ---- directed 32-bit vectors ----
    single32("s_m1_rne",      1'b0, 3'b000, 32'hFFFF_FFFF, 5'd3,  32'hBF80_0000, 1'b0);
    single32("s_min_rne",     1'b0, 3'b000, 32'h8000_0000, 5'd4,  32'hCF00_0000, 1'b0);
    single32("s_zero_rne",    1'b0, 3'b000, 32'h0000_0000, 5'd5,  32'h0000_0000, 1'b0);
    single32("s_zero_rdn",    1'b0, 3'b010, 32'h0000_0000, 5'd6,  32'h0000_0000, 1'b0);
    single32("s_one_rne",     1'b0, 3'b000, 32'h0000_0001, 5'd7,  32'h3F80_0000, 1'b0);
    single32("u_max_rne",     1'b1, 3'b000, 32'hFFFF_FFFF, 5'd8,  32'h4F80_0000, 1'b1);
    single32("u_max_rtz",     1'b1, 3'b001, 32'hFFFF_FFFF, 5'd9,  32'h4F7F_FFFF, 1'b1);
    single32("u_max_rmm",     1'b1, 3'b100, 32'hFFFF_FFFF, 5'd10, 32'h4F80_0000, 1'b1);
    single32("u_7fff_rne",    1'b1, 3'b000, 32'h7FFF_FFFF, 5'd11, 32'h4F00_0000, 1'b1);
    single32("s_tie_rne",     1'b0, 3'b000, 32'h0100_0001, 5'd12, 32'h4B80_0000, 1'b1);
    single32("s_tie_rup",     1'b0, 3'b011, 32'h0100_0001, 5'd13, 32'h4B80_0001, 1'b1);
    single32("s_tie_m111",    1'b0, 3'b111, 32'h0100_0001, 5'd14, 32'h4B80_0000, 1'b1);
    single32("s_ntie_rdn",    1'b0, 3'b010, 32'hFEFF_FFFF, 5'd15, 32'hCB80_0001, 1'b1);
    single32("s_ntie_rup",    1'b0, 3'b011, 32'hFEFF_FFFF, 5'd16, 32'hCB80_0000, 1'b1);

    // ---- flush with two in flight plus a new operand ----
    hold_v = 1'b0;
    pend_q.push_back('{uns: 1'b1, rm: 3'd0, op: 64'd1000, tag: 5'd1});
    pend_q.push_back('{uns: 1'b1, rm: 3'd0, op: 64'd2000, tag: 5'd2});
    cycle32(1'b1, 1'b1, 1'b0);
    cycle32(1'b1, 1'b1, 1'b0);
    pend_q.push_back('{uns: 1'b1, rm: 3'd0, op: 64'd3000, tag: 5'd3});
    cycle32(1'b1, 1'b1, 1'b1);
    check("flush_in_ready", last_in_ready, 1);
    exp_q.delete();
    pend_q.delete();
    for (int n = 0; n < 5; n++) begin
      cycle32(1'b0, 1'b1, 1'b0);
      check("flush_no_out", last_out_valid, 0);
    end
    single32("post_flush", 1'b0, 3'b000, 32'hFFFF_FFF0, 5'd17, 32'hC180_0000, 1'b0);

    // ---- backpressure: 5 operands against a blocked output ----
    hold_v = 1'b0;
    a0 = accepted; d0 = delivered;
    for (int n = 0; n < 5; n++) pend_q.push_back(rand_op(5'(20 + n)));
    repeat (6) cycle32(1'b1, 1'b0, 1'b0);
    check("bp_accepts", 64'(accepted - a0), 3);
    check("bp_in_ready", last_in_ready, 0);
    check("bp_out_valid", last_out_valid, 1);
    for (int n = 0; n < 40 && (pend_q.size() > 0 || exp_q.size() > 0); n++)
      cycle32(1'b1, 1'b1, 1'b0);
    check("bp_delivered", 64'(delivered - d0), 5);
    check("bp_drained", 64'(exp_q.size()), 0);

    // ---- randomized elastic stream ----
    for (int n = 0; n < 400; n++) begin
      if (pend_q.size() < 2) begin
        pend_q.push_back(rand_op(tag_ctr));
        tag_ctr = tag_ctr + 5'd1;
      end
      cycle32($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'b0);
    end
    for (int n = 0; n < 60 && (pend_q.size() > 0 || exp_q.size() > 0); n++)
      cycle32(1'b1, 1'b1, 1'b0);
    check("rand_drained", 64'(exp_q.size() + pend_q.size()), 0);

    // ---- reset with a full pipeline ----
    pend_q.push_back('{uns: 1'b0, rm: 3'd0, op: 64'h1234_5678, tag: 5'd7});
    pend_q.push_back('{uns: 1'b0, rm: 3'd0, op: 64'h8765_4321, tag: 5'd8});
    pend_q.push_back('{uns: 1'b1, rm: 3'd0, op: 64'h0F0F_0F0F, tag: 5'd9});
    repeat (3) cycle32(1'b1, 1'b0, 1'b0);
    cycle32(1'b0, 1'b0, 1'b0);
    check("full_in_ready", last_in_ready, 0);
    check("full_out_valid", last_out_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_out_valid", out_valid32, 0);
    check("mid_rst_result", result32, 0);
    check("mid_rst_nx", nx32, 0);
    check("mid_rst_tag", tag_o32, 0);
    check("mid_rst_in_ready", in_ready32, 1);
    reset = 1'b0;
    exp_q.delete();
    pend_q.delete();
    hold_v = 1'b0;
    single32("post_reset", 1'b1, 3'b000, 32'd5, 5'd18, 32'h40A0_0000, 1'b0);

    // ---- 64-bit instance ----
    single64("u64_max_rne", 1'b1, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 32'h5F80_0000, 1'b1);
    single64("s64_m1",      1'b0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 32'hBF80_0000, 1'b0);
    single64("u64_2p32",    1'b1, 3'b000, 64'h0000_0001_0000_0000, 5'd3, 32'h4F80_0000, 1'b0);
    single64("s64_min",     1'b0, 3'b000, 64'h8000_0000_0000_0000, 5'd4, 32'hDF00_0000, 1'b0);
    for (int n = 0; n < 20; n++) begin
      o = rand_op(5'(n));
      r = ref_cvt(o.op, 64, o.uns, o.rm);
      single64("rand64", o.uns, o.rm, o.op, o.tag, r[31:0], r[32]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
